uart_imem_loader: RTL and testbench

Writer-side counterpart to the instruction fetch path. It receives a program image as a byte stream from the UART receiver and writes it, word by word, into instruction memory. While loading, it holds the pipeline (cpu_hold). It validates length, an inter-byte timeout and an XOR checksum. On success it releases the CPU; on failure it holds the CPU and flags an error.

---
 rtl/uart_imem_loader_if.sv | 26 ++
 rtl/uart_imem_loader.sv | 151 +++++++++++++++
 tb/tb_uart_imem_loader.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_imem_loader_if.sv
// Byte-stream input from the UART receiver and word-write port into instruction memory.
interface uart_imem_loader_if #(
    parameter int unsigned ADDR_WIDTH = 14
);
    logic                  rx_valid;
    logic [7:0]            rx_byte;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;

    modport master (
        input  rx_valid,
        input  rx_byte,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport slave (
        output rx_valid,
        output rx_byte,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface

// File: rtl/uart_imem_loader.sv
// Loads a length-prefixed, XOR-checksummed program image from a UART byte stream
// into instruction memory while holding the CPU.
module uart_imem_loader #(
    parameter int unsigned ADDR_WIDTH     = 14,
    parameter int unsigned TIMEOUT_CYCLES = 10000000,
    parameter int unsigned CNT_WIDTH      = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    uart_imem_loader_if.master     bus,
    output logic                   cpu_hold,
    output logic                   busy,
    output logic                   load_done,
    output logic                   load_error,
    output logic [15:0]            words_loaded
);
    localparam int unsigned MAX_WORDS = 32'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_RUN,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [7:0]           len_lo;
    logic [15:0]          len;
    logic [15:0]          len_full;
    logic [23:0]          word_sr;
    logic [7:0]           checksum;
    logic [1:0]           byte_idx;
    logic [CNT_WIDTH-1:0] tmo_cnt;
    logic                 loading;
    logic                 tmo_hit;
    logic                 clear;
    logic                 take;
    logic                 word_done;

    always_ff @(posedge clk) begin
        if (rst) state <= S_RUN;
        else     state <= state_next;
    end

    // Next-state decode plus datapath strobes
    always_comb begin
        state_next = state;
        clear      = 1'b0;
        take       = 1'b0;
        word_done  = 1'b0;
        len_full   = {bus.rx_byte, len_lo};
        loading    = (state inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK});
        tmo_hit    = loading && !bus.rx_valid &&
                     (tmo_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
        case (state)
            S_RUN: begin
                if (start) begin
                    state_next = S_LEN_LO;
                    clear      = 1'b1;
                end
            end
            S_LEN_LO: begin
                if (bus.rx_valid) state_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (bus.rx_valid) begin
                    if (32'(len_full) > MAX_WORDS) state_next = S_ERROR;
                    else if (len_full == 16'd0)    state_next = S_CHECK;
                    else                           state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (bus.rx_valid) begin
                    take = 1'b1;
                    if (byte_idx == 2'd3) begin
                        word_done = 1'b1;
                        if (words_loaded + 16'd1 == len) state_next = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (bus.rx_valid) state_next = (bus.rx_byte == checksum) ? S_DONE : S_ERROR;
            end
            S_DONE: state_next = S_RUN;
            S_ERROR: begin
                if (start) begin
                    state_next = S_LEN_LO;
                    clear      = 1'b1;
                end
            end
            default: state_next = S_RUN;
        endcase
        // Timeout only fires on an idle cycle, so a byte arriving that cycle wins
        if (tmo_hit) state_next = S_ERROR;
    end

    // Datapath, memory write port and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            len_lo         <= '0;
            len            <= '0;
            word_sr        <= '0;
            checksum       <= '0;
            byte_idx       <= '0;
            tmo_cnt        <= '0;
            words_loaded   <= '0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            cpu_hold       <= 1'b0;
            busy           <= 1'b0;
            load_done      <= 1'b0;
            load_error     <= 1'b0;
        end else begin
            bus.imem_we <= word_done;

            if (clear || (loading && bus.rx_valid)) tmo_cnt <= '0;
            else if (loading)                       tmo_cnt <= tmo_cnt + CNT_WIDTH'(1);

            if (state == S_LEN_LO && bus.rx_valid) len_lo <= bus.rx_byte;
            if (state == S_LEN_HI && bus.rx_valid) len    <= len_full;

            if (clear) begin
                words_loaded <= '0;
                checksum     <= '0;
                byte_idx     <= '0;
                word_sr      <= '0;
            end else if (take) begin
                word_sr  <= {bus.rx_byte, word_sr[23:8]};
                checksum <= checksum ^ bus.rx_byte;
                byte_idx <= byte_idx + 2'd1;
            end

            if (word_done) begin
                bus.imem_addr  <= ADDR_WIDTH'(words_loaded);
                bus.imem_wdata <= {bus.rx_byte, word_sr};
                words_loaded   <= words_loaded + 16'd1;
            end

            cpu_hold   <= (state_next != S_RUN);
            busy       <= (state_next inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE});
            load_done  <= (state_next == S_DONE);
            load_error <= (state_next == S_ERROR);
        end
    end
endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed and randomized program-image loads checked against a stream-level model
// of expected writes, checksum outcome and CPU hold behaviour.
module tb_uart_imem_loader;
    localparam int unsigned AW   = 4;
    localparam int unsigned TMO  = 100;
    localparam int unsigned CW   = 24;
    localparam int unsigned MAXW = 16;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic        cpu_hold;
    logic        busy;
    logic        load_done;
    logic        load_error;
    logic [15:0] words_loaded;

    int checks = 0;
    int errors = 0;

    uart_imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

    uart_imem_loader #(
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TMO),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .bus         (bus.master),
        .cpu_hold    (cpu_hold),
        .busy        (busy),
        .load_done   (load_done),
        .load_error  (load_error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // Write log and observed memory image, sampled before the DUT updates on each edge
    logic [AW-1:0] wr_addr_q[$];
    logic [31:0]   wr_data_q[$];
    logic [31:0]   mem_obs[MAXW];
    int            done_cnt = 0;

    always @(posedge clk) begin
        if (bus.imem_we) begin
            wr_addr_q.push_back(bus.imem_addr);
            wr_data_q.push_back(bus.imem_wdata);
            mem_obs[bus.imem_addr] <= bus.imem_wdata;
        end
        if (load_done) done_cnt <= done_cnt + 1;
    end

    logic [31:0] word_buf[MAXW];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xsum(input int n);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < n; i++)
            for (int b = 0; b < 4; b++)
                x = x ^ 8'(word_buf[i] >> (8 * b));
        return x;
    endfunction

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < int'(MAXW); i++) word_buf[i] = $urandom;
    endtask

    // Full load of n words from word_buf; flip != 0 corrupts the checksum byte
    task automatic run_load(input int n, input logic [7:0] flip, input bit mid_start, input string tag);
        int  wb;
        int  db;
        bit  ok;
        wb = wr_addr_q.size();
        db = done_cnt;
        ok = (flip == 8'h00);
        pulse_start();
        chk({tag, ":busy_start"}, 32'(busy), 32'd1);
        send_byte(8'(n));
        idle($urandom_range(0, 3));
        send_byte(8'(n >> 8));
        if (n > int'(MAXW)) begin
            chk({tag, ":len_err"}, 32'(load_error), 32'd1);
            chk({tag, ":len_hold"}, 32'(cpu_hold), 32'd1);
            chk({tag, ":len_busy"}, 32'(busy), 32'd0);
            idle(3);
            chk({tag, ":len_nwr"}, 32'(wr_addr_q.size() - wb), 32'd0);
            chk({tag, ":len_wl"}, 32'(words_loaded), 32'd0);
            return;
        end
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 4; b++) begin
                idle($urandom_range(0, 3));
                send_byte(8'(word_buf[i] >> (8 * b)));
                if (b == 3) chk({tag, ":we_latency"}, 32'(bus.imem_we), 32'd1);
                if (mid_start && i == 0 && b == 3) pulse_start();
            end
        end
        idle($urandom_range(0, 3));
        send_byte(xsum(n) ^ flip);
        if (ok) begin
            chk({tag, ":done"}, 32'(load_done), 32'd1);
            chk({tag, ":hold_in_done"}, 32'(cpu_hold), 32'd1);
            idle(1);
            chk({tag, ":hold_released"}, 32'(cpu_hold), 32'd0);
            chk({tag, ":done_pulse"}, 32'(load_done), 32'd0);
            chk({tag, ":busy_run"}, 32'(busy), 32'd0);
        end else begin
            chk({tag, ":cs_err"}, 32'(load_error), 32'd1);
            chk({tag, ":cs_hold"}, 32'(cpu_hold), 32'd1);
            chk({tag, ":cs_busy"}, 32'(busy), 32'd0);
            idle(2);
        end
        idle(1);
        chk({tag, ":nwr"}, 32'(wr_addr_q.size() - wb), 32'(n));
        for (int i = 0; i < n && wb + i < wr_addr_q.size(); i++) begin
            chk({tag, ":addr"}, 32'(wr_addr_q[wb + i]), 32'(i));
            chk({tag, ":data"}, wr_data_q[wb + i], word_buf[i]);
        end
        chk({tag, ":ndone"}, 32'(done_cnt - db), ok ? 32'd1 : 32'd0);
        chk({tag, ":wl"}, 32'(words_loaded), 32'(n));
        chk({tag, ":err_level"}, 32'(load_error), ok ? 32'd0 : 32'd1);
    endtask

    initial begin
        int wb;
        int db;
        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'h00;

        idle(3);
        chk("rst_hold", 32'(cpu_hold), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(load_error), 32'd0);
        chk("rst_wl", 32'(words_loaded), 32'd0);
        chk("rst_we", 32'(bus.imem_we), 32'd0);
        chk("rst_addr", 32'(bus.imem_addr), 32'd0);
        chk("rst_wdata", bus.imem_wdata, 32'd0);
        rst = 1'b0;
        idle(1);

        // Bytes in RUN are ignored
        wb = wr_addr_q.size();
        for (int i = 0; i < 9; i++) send_byte(8'($urandom));
        idle(2);
        chk("run_rx_nwr", 32'(wr_addr_q.size() - wb), 32'd0);
        chk("run_rx_hold", 32'(cpu_hold), 32'd0);

        // Directed image: two RISC-V instructions
        word_buf[0] = 32'h0000_0013;
        word_buf[1] = 32'h0010_0093;
        run_load(2, 8'h00, 1'b0, "good");
        run_load(2, 8'h01, 1'b0, "badcs");

        // ERROR ignores bytes until start
        wb = wr_addr_q.size();
        for (int i = 0; i < 5; i++) send_byte(8'($urandom));
        idle(2);
        chk("err_sticky", 32'(load_error), 32'd1);
        chk("err_nwr", 32'(wr_addr_q.size() - wb), 32'd0);
        run_load(2, 8'h00, 1'b0, "retry");

        // Timeout after a single data byte
        wb = wr_addr_q.size();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        idle(int'(TMO) - 1);
        chk("tmo_before", 32'(load_error), 32'd0);
        chk("tmo_hold", 32'(cpu_hold), 32'd1);
        idle(1);
        chk("tmo_err", 32'(load_error), 32'd1);
        chk("tmo_nwr", 32'(wr_addr_q.size() - wb), 32'd0);

        // start together with rx_valid: the byte is dropped
        db = done_cnt;
        start        = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_byte  = 8'h07;
        @(negedge clk);
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        chk("drop_done", 32'(load_done), 32'd1);
        idle(2);
        chk("drop_ndone", 32'(done_cnt - db), 32'd1);

        // Length boundaries
        run_load(0, 8'h00, 1'b0, "len0");
        run_load(int'(MAXW) + 1, 8'h00, 1'b0, "len17");
        fill_random();
        wb = wr_addr_q.size();
        run_load(int'(MAXW), 8'h00, 1'b1, "len16");
        chk("len16_last_addr", 32'(wr_addr_q[wr_addr_q.size() - 1]), 32'(MAXW - 1));

        // Reset after two words of a four-word load
        fill_random();
        wb = wr_addr_q.size();
        pulse_start();
        send_byte(8'h04);
        send_byte(8'h00);
        for (int i = 0; i < 2; i++)
            for (int b = 0; b < 4; b++) send_byte(8'(word_buf[i] >> (8 * b)));
        idle(1);
        rst = 1'b1;
        idle(1);
        chk("mid_rst_hold", 32'(cpu_hold), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_wl", 32'(words_loaded), 32'd0);
        chk("mid_rst_we", 32'(bus.imem_we), 32'd0);
        chk("mid_rst_err", 32'(load_error), 32'd0);
        rst = 1'b0;
        idle(2);
        chk("mid_rst_nwr", 32'(wr_addr_q.size() - wb), 32'd2);
        chk("mid_rst_mem0", mem_obs[0], word_buf[0]);
        chk("mid_rst_mem1", mem_obs[1], word_buf[1]);

        // Randomized images, lengths and checksum corruption
        for (int t = 0; t < 8; t++) begin
            int         n;
            logic [7:0] flip;
            fill_random();
            n    = $urandom_range(0, int'(MAXW) + 2);
            flip = ($urandom_range(0, 3) == 0) ? 8'(32'd1 << $urandom_range(0, 7)) : 8'h00;
            run_load(n, flip, t[0], "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
